// File: rtl/demux1to8_nbit_pipe.sv
// 1-to-8 demultiplexer with one registered holding slot per output channel.
// Optional accepted-word counter on xfer_cnt when DEMUX_XFER_CNT_EN is defined.
module demux1to8_nbit_pipe #(
  parameter int N = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2:0]     in_sel,
  input  logic [N-1:0]   in_data,
  output logic [7:0]     out_valid,
  input  logic [7:0]     out_ready,
  output logic [8*N-1:0] out_data
`ifdef DEMUX_XFER_CNT_EN
  ,
  output logic [15:0]    xfer_cnt
`endif
);

  logic [7:0]     r_valid;
  logic [8*N-1:0] r_data;
  logic           w_accept;

  // A full slot still takes a new word when its consumer drains it in the same cycle.
  assign in_ready  = ~r_valid[in_sel] | out_ready[in_sel];
  assign w_accept  = in_valid & in_ready;
  assign out_valid = r_valid;
  assign out_data  = r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (w_accept && (in_sel == 3'(k))) begin
          r_valid[k]        <= 1'b1;
          r_data[k*N +: N]  <= in_data;
        end else if (r_valid[k] && out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

`ifdef DEMUX_XFER_CNT_EN
  logic [15:0] r_xfer_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xfer_cnt <= '0;
    end else if (w_accept) begin
      r_xfer_cnt <= r_xfer_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_xfer_cnt;
`endif

endmodule
